// File: rtl/sha_bridge_pkg.sv
// sha_bridge_pkg: shared state encoding and width helpers for sha_host_bridge.
package sha_bridge_pkg;

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

    function automatic int beats(input int w, input int io);
        return w / io;
    endfunction

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) if ((1 << i) < v) r = i + 1;
        return (r < 1) ? 1 : r;
    endfunction

    // MSB-first slot k of a total-bit vector, io bits per slot
    function automatic int msb_base(input int total, input int io, input int k);
        return total - 1 - k * io;
    endfunction

endpackage

// File: rtl/sha_host_bridge_rise_det.sv
// rise_det: rising-edge detector against a registered copy of the input.
module rise_det (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic rise
);

    logic q;

    always_ff @(posedge clk) q <= rst ? 1'b0 : d;

    assign rise = d & ~q;

endmodule

// File: rtl/sha_host_bridge.sv
// sha_host_bridge: host beat <-> core word/digest bridge for the SHA256d core.
// Define SHA_BRIDGE_TIMEOUT_EN to add a handshake watchdog that flags err and aborts.
module sha_host_bridge
    import sha_bridge_pkg::*;
#(
    parameter int IO_W     = 8,
    parameter int WORD_W   = 32,
    parameter int DIGEST_W = 256,
    parameter int ADDR_W   = 5
`ifdef SHA_BRIDGE_TIMEOUT_EN
    , parameter int TIMEOUT_CYC = 1024
`endif
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                abort,
    input  logic                host_rdy,
    input  logic [IO_W-1:0]     host_din,
    output logic [IO_W-1:0]     host_dout,
    output logic                host_rq,
    output logic                done,
    output logic                err,
    output logic                core_start,
    output logic                core_rdy,
    output logic [WORD_W-1:0]   core_data,
    input  logic [ADDR_W-1:0]   core_addr,
    input  logic                core_rq,
    input  logic                core_done,
    input  logic [DIGEST_W-1:0] core_digest
);

    localparam int BEATS  = beats(WORD_W, IO_W);
    localparam int DBEATS = beats(DIGEST_W, IO_W);
    localparam int CW     = clog2(BEATS > DBEATS ? BEATS : DBEATS);
    localparam int SW     = ADDR_W + CW;

    state_t                state;
    logic [CW-1:0]         k;
    logic                  pending;
    logic [DIGEST_W-1:0]   digest_q;
    logic                  rdy_rise;
    logic                  rq_rise;
    logic                  xfer;
    logic                  to;
    logic                  kill;
    logic [SW-1:0]         status;

    rise_det u_rdy (.clk(clk), .rst(rst), .d(host_rdy), .rise(rdy_rise));
    rise_det u_rq  (.clk(clk), .rst(rst), .d(core_rq),  .rise(rq_rise));

    assign xfer   = rdy_rise & host_rq;
    assign status = {core_addr, k};
    assign kill   = abort | to;

    always_comb host_dout = (state == DRAIN) ? digest_q[msb_base(DIGEST_W, IO_W, int'(k)) -: IO_W]
                                             : IO_W'(status);

`ifdef SHA_BRIDGE_TIMEOUT_EN
    localparam int WW = clog2(TIMEOUT_CYC + 1);
    logic [WW-1:0] wd;

    assign to = host_rq & ~rdy_rise & (wd == WW'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk) wd <= (rst | kill | ~host_rq | rdy_rise) ? '0 : wd + 1'b1;
`else
    assign to = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            k          <= '0;
            pending    <= 1'b0;
            digest_q   <= '0;
            host_rq    <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            core_start <= 1'b0;
            core_rdy   <= 1'b0;
            core_data  <= '0;
        end else begin
            core_start <= 1'b0;
            core_rdy   <= 1'b0;
            if (kill) begin
                state   <= IDLE;
                host_rq <= 1'b0;
                done    <= 1'b0;
                pending <= 1'b0;
                k       <= '0;
                err     <= err | to;
            end else begin
                case (state)
                    IDLE: if (start) begin
                        core_start <= 1'b1;
                        err        <= 1'b0;
                        state      <= FETCH;
                    end
                    FETCH: if (core_done) begin
                        digest_q <= core_digest;
                        done     <= 1'b1;
                        pending  <= 1'b0;
                        host_rq  <= 1'b0;
                        k        <= '0;
                        state    <= DRAIN;
                    end else begin
                        if (xfer) begin
                            core_data[msb_base(WORD_W, IO_W, int'(k)) -: IO_W] <= host_din;
                            host_rq <= 1'b0;
                            if (k == CW'(BEATS - 1)) begin
                                k        <= '0;
                                pending  <= 1'b0;
                                core_rdy <= 1'b1;
                            end else k <= k + 1'b1;
                        end else if (pending) host_rq <= 1'b1;
                        // a new request while one is outstanding is an error, not a restart
                        if (rq_rise) begin
                            if (pending) err <= 1'b1;
                            else begin
                                pending <= 1'b1;
                                host_rq <= 1'b1;
                            end
                        end
                    end
                    DRAIN: if (xfer) begin
                        host_rq <= 1'b0;
                        if (k == CW'(DBEATS - 1)) begin
                            done  <= 1'b0;
                            k     <= '0;
                            state <= IDLE;
                        end else k <= k + 1'b1;
                    end else host_rq <= 1'b1;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
